// File: rtl/ssm_ctrl_pkg.sv
// Shared encodings and widths for the register transfer controller.
package ssm_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 6;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MOVE  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/tri_state_buffer.sv
// Bus driver: passes i_data through when enabled, otherwise releases the bus (high-Z).
module tri_state_buffer #(
  parameter int W = 16
) (
  input  logic         i_en,
  input  logic [W-1:0] i_data,
  output tri   [W-1:0] o_bus
);

  assign o_bus = i_en ? i_data : {W{1'bz}};

endmodule

// File: rtl/register_transfer_controller.sv
// Single-command LOAD/STORE/MOVE sequencer for a 4-entry register file on a shared bus.
// Optional macro RTC_PERF_COUNTER_EN adds ctrl_transfer_count (successful transfers, wraps).
//
// state   | meaning
// IDLE    | ready for a command, bus released
// READ    | selected register drives the bus, value captured into hold
// WRITE   | controller drives hold onto the bus, register strobed
// RESP    | one-cycle completion pulse with hold value / error flag
module register_transfer_controller #(
  parameter int DATA_W = ssm_ctrl_pkg::DATA_W,
  parameter int ADDR_W = ssm_ctrl_pkg::ADDR_W
) (
  input  logic              controller_clock,
  input  logic              controller_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [1:0]        cmd_src,
  input  logic [1:0]        cmd_dst,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] register_addr,
  output logic              bus_register_input_en,
  output logic              bus_register_out_en,
  input  logic [DATA_W-1:0] bus_controller_input,
  output tri   [DATA_W-1:0] bus_controller_output
`ifdef RTC_PERF_COUNTER_EN
  ,
  output logic [15:0]       ctrl_transfer_count
`endif
);
  import ssm_ctrl_pkg::*;

  state_e            r_state;
  state_e            w_next;
  op_e               r_op;
  logic [1:0]        r_src;
  logic [1:0]        r_dst;
  logic [DATA_W-1:0] r_hold;
  logic              r_err;
  logic              w_drive_en;

  always_ff @(posedge controller_clock or posedge controller_reset) begin
    if (controller_reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_LOAD;
      r_src   <= '0;
      r_dst   <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cmd_valid) begin
        r_op   <= op_e'(cmd_op);
        r_src  <= cmd_src;
        r_dst  <= cmd_dst;
        r_err  <= (op_e'(cmd_op) == OP_RSVD);
        // Reserved ops report zero data, so clear hold unless a LOAD payload arrives
        r_hold <= (op_e'(cmd_op) == OP_LOAD) ? cmd_data : '0;
      end else if (r_state == ST_READ) begin
        r_hold <= bus_controller_input;
      end
    end
  end

  always_comb begin
    w_next                = r_state;
    cmd_ready             = 1'b0;
    rsp_valid             = 1'b0;
    rsp_data              = '0;
    rsp_error             = 1'b0;
    register_addr         = '0;
    bus_register_input_en = 1'b0;
    bus_register_out_en   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (op_e'(cmd_op))
            OP_LOAD: w_next = ST_WRITE;
            OP_RSVD: w_next = ST_RESP;
            default: w_next = ST_READ;
          endcase
        end
      end
      ST_READ: begin
        register_addr       = {{(ADDR_W-2){1'b0}}, r_src};
        bus_register_out_en = 1'b1;
        w_next              = (r_op == OP_MOVE) ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        register_addr         = {{(ADDR_W-2){1'b0}}, r_dst};
        bus_register_input_en = 1'b1;
        w_next                = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = r_hold;
        rsp_error = r_err;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_drive_en = (r_state == ST_WRITE);

  tri_state_buffer #(.W(DATA_W)) u_bus_drv (
    .i_en   (w_drive_en),
    .i_data (r_hold),
    .o_bus  (bus_controller_output)
  );

`ifdef RTC_PERF_COUNTER_EN
  logic [15:0] r_xfer_count;

  always_ff @(posedge controller_clock or posedge controller_reset) begin
    if (controller_reset) begin
      r_xfer_count <= '0;
    end else if (r_state == ST_RESP && !r_err) begin
      r_xfer_count <= r_xfer_count + 16'd1;
    end
  end

  assign ctrl_transfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_register_transfer_controller.sv
// Bench for register_transfer_controller: per-command expected trace model, register-file responder,
// and hand-computed latency/data/register expectations for each directed command.
module tb_register_transfer_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [1:0]  cmd_src = '0;
  logic [1:0]  cmd_dst = '0;
  logic [15:0] cmd_data = '0;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_error;
  logic [5:0]  raddr;
  logic        ie;
  logic        oe;
  logic [15:0] bus_in;
  wire  [15:0] bus_out;
`ifdef RTC_PERF_COUNTER_EN
  logic [15:0] xfer_count;
`endif

  // hand-computed expectations attached to the command being offered
  int          lit_lat = 0;
  logic [15:0] lit_data = '0;
  logic        lit_err = 1'b0;
  logic        lit_rfc = 1'b0;
  logic [1:0]  lit_rfi = '0;
  logic [15:0] lit_rfv = '0;
  bit          pre_req = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  register_transfer_controller dut (
    .controller_clock      (clk),
    .controller_reset      (rst),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_op                (cmd_op),
    .cmd_src               (cmd_src),
    .cmd_dst               (cmd_dst),
    .cmd_data              (cmd_data),
    .rsp_valid             (rsp_valid),
    .rsp_data              (rsp_data),
    .rsp_error             (rsp_error),
    .register_addr         (raddr),
    .bus_register_input_en (ie),
    .bus_register_out_en   (oe),
    .bus_controller_input  (bus_in),
    .bus_controller_output (bus_out)
`ifdef RTC_PERF_COUNTER_EN
    ,
    .ctrl_transfer_count   (xfer_count)
`endif
  );

  // register file responder
  logic [15:0] rf [4] = '{16'h0000, 16'h1234, 16'h0000, 16'hA5A5};
  assign bus_in = oe ? rf[raddr[1:0]] : 16'hDEAD;
  always @(posedge clk) if (ie) rf[raddr[1:0]] <= bus_out;

  // what the DUT saw at each edge
  logic        s_valid, s_lrfc, s_lerr;
  logic [1:0]  s_op, s_src, s_dst, s_lrfi;
  logic [15:0] s_data, s_ldata, s_lrfv;
  int          s_llat;
  always @(posedge clk) begin
    s_valid <= cmd_valid; s_op <= cmd_op; s_src <= cmd_src; s_dst <= cmd_dst; s_data <= cmd_data;
    s_llat <= lit_lat; s_ldata <= lit_data; s_lerr <= lit_err;
    s_lrfc <= lit_rfc; s_lrfi <= lit_rfi; s_lrfv <= lit_rfv;
  end

  typedef struct {
    bit          rdy, oe, ie, rv, re;
    logic [5:0]  addr;
    logic [15:0] bus, rd;
  } exp_t;

  function automatic exp_t mk(bit rdy, bit oe_, bit ie_, logic [1:0] a, logic [15:0] b,
                              bit rv, logic [15:0] rd, bit re);
    exp_t e;
    e.rdy = rdy; e.oe = oe_; e.ie = ie_; e.addr = {4'b0000, a};
    e.bus = b; e.rv = rv; e.rd = rd; e.re = re;
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model state
  exp_t        q[$];
  exp_t        e;
  logic [15:0] m_rf [4] = '{16'h0000, 16'h1234, 16'h0000, 16'hA5A5};
  bit          m_was_idle = 1'b1;
  bit          m_pend = 1'b0;
  logic [1:0]  m_pw_idx;
  logic [15:0] m_pw_val;
  logic [15:0] m_count = '0;
  int          m_age = 0;
  int          l_lat;
  logic [15:0] l_data, l_rfv;
  logic        l_err, l_rfc;
  logic [1:0]  l_rfi;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      m_was_idle = 1'b1;
      m_pend     = 1'b0;
      m_count    = '0;
      e = mk(1, 0, 0, 2'd0, 16'h0, 0, 16'h0, 0);
    end else begin
      if (m_pend) begin
        m_rf[m_pw_idx] = m_pw_val;
        m_pend = 1'b0;
      end
      if (m_was_idle && s_valid) begin
        case (s_op)
          2'b00: begin
            q.push_back(mk(0, 0, 1, s_dst, s_data, 0, 16'h0, 0));
            q.push_back(mk(0, 0, 0, 2'd0, 16'h0, 1, s_data, 0));
          end
          2'b01: begin
            q.push_back(mk(0, 1, 0, s_src, 16'h0, 0, 16'h0, 0));
            q.push_back(mk(0, 0, 0, 2'd0, 16'h0, 1, m_rf[s_src], 0));
          end
          2'b10: begin
            q.push_back(mk(0, 1, 0, s_src, 16'h0, 0, 16'h0, 0));
            q.push_back(mk(0, 0, 1, s_dst, m_rf[s_src], 0, 16'h0, 0));
            q.push_back(mk(0, 0, 0, 2'd0, 16'h0, 1, m_rf[s_src], 0));
          end
          default: q.push_back(mk(0, 0, 0, 2'd0, 16'h0, 1, 16'h0, 1));
        endcase
        m_age = 0;
        l_lat = s_llat; l_data = s_ldata; l_err = s_lerr;
        l_rfc = s_lrfc; l_rfi = s_lrfi; l_rfv = s_lrfv;
      end
      if (pre_req) m_count = 16'hFFFF;
      if (q.size() > 0) begin
        e = q.pop_front();
        m_was_idle = 1'b0;
        m_age++;
      end else begin
        e = mk(1, 0, 0, 2'd0, 16'h0, 0, 16'h0, 0);
        m_was_idle = 1'b1;
      end
    end
    check("cmd_ready", 32'(cmd_ready), 32'(e.rdy));
    check("out_en", 32'(oe), 32'(e.oe));
    check("in_en", 32'(ie), 32'(e.ie));
    check("addr", 32'(raddr), 32'(e.addr));
    if (e.ie) check("bus_drive", 32'(bus_out), 32'(e.bus));
    check("rsp_valid", 32'(rsp_valid), 32'(e.rv));
    check("rsp_data", 32'(rsp_data), 32'(e.rd));
    check("rsp_error", 32'(rsp_error), 32'(e.re));
`ifdef RTC_PERF_COUNTER_EN
    check("count", 32'(xfer_count), 32'(m_count));
`endif
    if (!rst) begin
      if (e.ie) begin
        m_pend = 1'b1; m_pw_idx = e.addr[1:0]; m_pw_val = e.bus;
      end
      if (e.rv) begin
        check("lit_latency", 32'(m_age), 32'(l_lat));
        check("lit_rsp_data", 32'(rsp_data), 32'(l_data));
        check("lit_rsp_error", 32'(rsp_error), 32'(l_err));
        if (l_rfc) check("lit_regfile", 32'(rf[l_rfi]), 32'(l_rfv));
        if (!e.re) m_count = m_count + 16'd1;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [1:0] s, input logic [1:0] d,
                      input logic [15:0] data, input int lat, input logic [15:0] ld,
                      input logic le, input logic rc, input logic [1:0] ri, input logic [15:0] rv);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_src = s; cmd_dst = d; cmd_data = data;
    lit_lat = lat; lit_data = ld; lit_err = le; lit_rfc = rc; lit_rfi = ri; lit_rfv = rv;
    n = 0;
    while (!cmd_ready) begin
      @(negedge clk); #1;
      n++;
      if (n > 20) begin
        $display("FAIL accept_timeout got=not_ready want=ready at %0t", $time);
        $fatal(1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic quiet(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    send(2'b00, 2'd0, 2'd2, 16'hBEEF, 2, 16'hBEEF, 1'b0, 1'b1, 2'd2, 16'hBEEF); quiet(3);
    send(2'b01, 2'd1, 2'd0, 16'h0000, 2, 16'h1234, 1'b0, 1'b0, 2'd0, 16'h0000); quiet(3);
    send(2'b10, 2'd3, 2'd0, 16'h0000, 3, 16'hA5A5, 1'b0, 1'b1, 2'd0, 16'hA5A5); quiet(3);
    send(2'b11, 2'd2, 2'd1, 16'h7777, 1, 16'h0000, 1'b1, 1'b1, 2'd1, 16'h1234); quiet(3);
    send(2'b10, 2'd2, 2'd2, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b1, 2'd2, 16'hBEEF); quiet(3);
    // reset during the READ cycle of a MOVE: register 1 must keep 0x1234
    send(2'b10, 2'd2, 2'd1, 16'h0000, 3, 16'hBEEF, 1'b0, 1'b0, 2'd0, 16'h0000);
    cmd_valid = 1'b0;
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    quiet(2);
    send(2'b01, 2'd1, 2'd0, 16'h0000, 2, 16'h1234, 1'b0, 1'b1, 2'd1, 16'h1234); quiet(2);
    // back-to-back with cmd_valid held high
    send(2'b00, 2'd0, 2'd1, 16'h0F0F, 2, 16'h0F0F, 1'b0, 1'b1, 2'd1, 16'h0F0F);
    send(2'b01, 2'd1, 2'd0, 16'h0000, 2, 16'h0F0F, 1'b0, 1'b0, 2'd0, 16'h0000);
    send(2'b10, 2'd1, 2'd3, 16'h0000, 3, 16'h0F0F, 1'b0, 1'b1, 2'd3, 16'h0F0F);
    quiet(4);
`ifdef RTC_PERF_COUNTER_EN
    force dut.r_xfer_count = 16'hFFFF;
    pre_req = 1'b1;
    @(negedge clk); #1;
    release dut.r_xfer_count;
    pre_req = 1'b0;
    send(2'b00, 2'd0, 2'd0, 16'h0001, 2, 16'h0001, 1'b0, 1'b1, 2'd0, 16'h0001); quiet(3);
`endif
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/register_transfer_controller.md
# register_transfer_controller

Sequencer that owns the shared 16-bit register bus and executes one register-file transfer command at a time: LOAD (external data into a register), STORE (register out to the requester) and MOVE (register to register). It sits between the instruction/control logic and the 4-entry register file. It drives the file's address, input-enable and output-enable. It also drives the bus through a tri-state during writes and samples the bus during reads.

## Interface
Parameters:
- DATA_W, 16, bus and register width
- ADDR_W, 6, register-file address width; only bits [1:0] are ever non-zero

Ports:
- controller_clock  in  1  single clock, rising edge
- controller_reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LOAD, 01 STORE, 10 MOVE, 11 reserved
- cmd_src  in  2  source register index (STORE, MOVE)
- cmd_dst  in  2  destination register index (LOAD, MOVE)
- cmd_data  in  DATA_W  LOAD payload
- rsp_valid  out  1  one-cycle completion pulse, no backpressure
- rsp_data  out  DATA_W  value transferred
- rsp_error  out  1  qualifies rsp_valid; reserved op
- register_addr  out  ADDR_W  address to register file
- bus_register_input_en  out  1  register-file write strobe
- bus_register_out_en  out  1  register file drives bus
- bus_controller_input  in  DATA_W  sampled bus value
- bus_controller_output  out  DATA_W  tri-stated bus drive
- ctrl_transfer_count  out  16  present only with RTC_PERF_COUNTER_EN

## Operation
- Command is accepted on a cycle with cmd_valid && cmd_ready. At acceptance, op/src/dst/data are captured into holding registers; later cmd_* changes are ignored.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: LOAD -> WRITE; STORE or MOVE -> READ; reserved -> RESP with error flag.
  - READ: register_addr = src, bus_register_out_en = 1. Bus value is captured into the hold register at the cycle's end. MOVE -> WRITE; STORE -> RESP.
  - WRITE: register_addr = dst, bus_register_input_en = 1, bus_controller_output drives the hold value. -> RESP.
  - RESP: rsp_valid = 1 with rsp_data = hold value and rsp_error = error flag. -> IDLE.
- For LOAD, the hold register is loaded from cmd_data at acceptance.
- bus_register_out_en and controller drive are never high in the same cycle. Outside WRITE, bus_controller_output is high-Z.
- register_addr[5:2] is always 0. register_addr is 0 in IDLE and RESP.
- A reserved op produces no register-file activity. rsp_data is 0 for a reserved op.
- MOVE with src == dst is legal and rewrites the same value.

## Timing
- Reset values (asynchronous):
  - state = IDLE, cmd_ready = 1
  - rsp_valid = 0, rsp_data = 0, rsp_error = 0
  - register_addr = 0, both enables = 0, bus drive high-Z
  - hold register = 0, ctrl_transfer_count = 0
- Latency, counted from the acceptance cycle (cycle 0) to rsp_valid:
  - LOAD: 2 cycles (WRITE in cycle 1).
  - STORE: 2 cycles (READ in cycle 1).
  - MOVE: 3 cycles (READ 1, WRITE 2).
  - Reserved: 1 cycle.
- cmd_ready falls the cycle after acceptance and rises in the cycle after RESP. The next command can therefore be accepted in the cycle following rsp_valid. Throughput is one command per 2–4 cycles.
- All outputs are registered or decoded from state only; there is no combinational path from cmd_* to the register-file controls.
- Reset asserted mid-operation: return to IDLE immediately. Enables drop asynchronously, no rsp_valid is issued, and a partially completed MOVE leaves the destination unwritten.

## Configuration
- RTC_PERF_COUNTER_EN defined: adds port ctrl_transfer_count.
  - Increments by 1 in every cycle where rsp_valid && !rsp_error.
  - Wraps from 0xFFFF to 0x0000.
  - Cleared only by reset.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package ssm_ctrl_pkg holds:
  - the op encoding enum (LOAD/STORE/MOVE/RSVD)
  - the FSM state enum
  - DATA_W and ADDR_W constants
- One sub-module: the existing tri_state_buffer, instanced for bus_controller_output. Its enable is (state == WRITE). FSM and datapath stay in this module.

## Test plan
- Reset: assert controller_reset mid-stream -> all outputs at reset values; cmd_ready = 1 in the next cycle; no rsp_valid.
- LOAD dst=2 data=0xBEEF -> bus_register_input_en high in cycle 1 with register_addr=2 and bus=0xBEEF; rsp_valid in cycle 2 with rsp_data=0xBEEF, rsp_error=0.
- STORE src=1, with the register-file model driving 0x1234 -> bus_register_out_en high in cycle 1 with register_addr=1; rsp_valid in cycle 2 with rsp_data=0x1234.
- MOVE src=3 dst=0, register 3 = 0xA5A5 -> READ addr 3 in cycle 1, WRITE addr 0 with 0xA5A5 in cycle 2, rsp in cycle 3; register 0 = 0xA5A5.
- Reserved op 11 -> rsp_valid with rsp_error=1 in cycle 1; no enables ever high; counter unchanged.
- Back-to-back: cmd_valid held high with LOAD, STORE, MOVE -> each accepted in the cycle after the previous rsp_valid. With RTC_PERF_COUNTER_EN, count = 3; preload 0xFFFF and complete one transfer -> count = 0.
